disaster_alarm_controller: RTL and testbench
============================================

# disaster_alarm_controller

Sequencing and alarm-management stage behind the combinational disaster detector. It takes the detector's four per-hazard flags (flood, cyclone, earthquake, tsunami) at each sensor sample. It requires each flag to persist over consecutive samples before raising an alarm, and latches alarms until the operator acknowledges them. It also time-shares the single hazard display between all latched hazards in round-robin order.

## Interface
Parameters:
- PERSIST, 4: consecutive qualifying samples needed to latch a hazard; legal range ≥1.
- HOLD_CYCLES, 8: clock cycles each latched hazard is shown on the display before rotating; legal range ≥1.
- ESC_CYCLES, 64: unacknowledged-alert cycles before escalation. Present only with DISASTER_ESCALATE_EN.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset; synchronous, active-high.
- sample_valid, in, 1: detector flags are valid this cycle.
- hazard_in, in, 4: detector flags in the order [0]=flood, [1]=cyclone, [2]=earthquake, [3]=tsunami.
- ack, in, 1: operator acknowledge, level-sampled each cycle.
- alarm_latched, out, 4: latched hazards, using the same bit order as hazard_in.
- disp_sel, out, 2: index of the hazard currently displayed.
- disp_valid, out, 1: disp_sel is meaningful.
- buzzer, out, 1: high in ALERT.
- safe_led, out, 1: high in SAFE.
- danger_led, out, 1: high whenever not SAFE.
- escalate, out, 1: present only with DISASTER_ESCALATE_EN.

## Operation
- **Per-hazard persistence counter.**
  - Width is $clog2(PERSIST+1).
  - On a sample_valid cycle with the flag at 1: the counter increments, saturating at PERSIST.
  - On a sample_valid cycle with the flag at 0: the counter clears to 0.
  - When sample_valid=0: the counter holds.
- **Latch set.** A hazard's latch bit sets on the edge at which its counter reaches PERSIST.
- **Latch clear.** A latched bit clears on an edge with ack=1 only if that hazard's counter is 0, meaning its condition has gone away. A hazard that is still active stays latched through ack.
- **Set/clear priority.** Set beats clear on the same edge.
- **FSM states:** SAFE, ALERT, ACKED.
  - SAFE→ALERT: next-state alarm_latched≠0.
  - ALERT→ACKED: ack=1 and at least one bit remains latched after the clears.
  - ALERT or ACKED→SAFE: next-state alarm_latched==0.
  - ACKED→ALERT: any new bit sets.
- **Display rotation.**
  - Hazard encoding: flood=0, cyclone=1, quake=2, tsunami=3.
  - On the 0→nonzero transition of alarm_latched, disp_sel loads the highest-priority latched hazard (tsunami > quake > cyclone > flood).
  - A dwell counter runs from 0 to HOLD_CYCLES-1.
  - On expiry, disp_sel moves to the next latched index upward with wrap-around (3→0), and the dwell counter restarts.
  - If exactly one hazard is latched, disp_sel stays on it.
  - If the displayed hazard clears, disp_sel advances on the next edge to the next latched index, and dwell restarts.
  - disp_valid equals alarm_latched≠0, registered.

## Timing
- All outputs are registered.
- Reset values:
  - alarm_latched=0, disp_sel=0, disp_valid=0.
  - buzzer=0, safe_led=1, danger_led=0.
  - escalate=0.
  - All counters=0; FSM in SAFE.
- **Latch latency.** alarm_latched is visible in the cycle after the edge sampling the PERSIST-th consecutive qualifying sample.
- **With PERSIST=1:** the latch sets one edge after the first qualifying sample.
- **Derived outputs.** buzzer, safe_led and danger_led update on the same edge as the latch change: the FSM uses next-state latches.
- **ack latency.** ack acts on the edge where it is sampled. Holding ack high has no extra effect beyond repeated clear attempts.
- **ack in SAFE.** Ignored.
- **Reset mid-operation.** Returns every register to its reset value on that edge, regardless of sample_valid or ack.
- **Gaps in sample_valid.** Do not break persistence; only a 0-flag sample does.

## Configuration
- **DISASTER_ESCALATE_EN defined:**
  - An escalation counter of width $clog2(ESC_CYCLES+1) counts cycles spent in ALERT.
  - escalate goes high on the edge the count reaches ESC_CYCLES, and stays high until the FSM leaves ALERT.
  - Leaving ALERT clears both the counter and escalate.
- **DISASTER_ESCALATE_EN undefined:** the escalate port, the ESC_CYCLES parameter and all escalation logic are absent. Everything else is identical.

## Structure
- **Package disaster_pkg** holds:
  - Hazard index constants HZ_FLOOD=0, HZ_CYCLONE=1, HZ_QUAKE=2, HZ_TSUNAMI=3.
  - NUM_HAZARDS=4.
  - The alarm_state_t enum {SAFE, ALERT, ACKED}.
- **Sub-module hazard_persist**, instantiated four times. It contains one persistence counter plus its latch bit, with ports for flag, sample_valid, clear request and latched output.
- **Top level** holds the FSM, the display rotator and the optional escalation logic.

## Test plan
All scenarios use PERSIST=4 and HOLD_CYCLES=8.
- **Reset:** assert rst for 2 cycles with hazard_in=4'b1111 and sample_valid=1 → all outputs at reset values; safe_led=1.
- **Persistence break:** flood for 3 samples, one 0 sample, then 4 samples → alarm_latched=4'b0001 only after the 4th sample of the second run; buzzer=1; disp_sel=0.
- **Ack rules:** with flood still active, ack → latch stays 4'b0001 and the FSM goes to ACKED (buzzer=0, danger_led=1). Drop flood, then ack → latch clears, SAFE, safe_led=1.
- **Simultaneous events:**
  - Quake and tsunami reach PERSIST together → disp_sel=3 first, then 2 after 8 cycles, then 3 after 8 more (wrap).
  - A new cyclone latch on the same edge as ack → cyclone is set and the FSM is in ALERT.
- **Displayed hazard clears:** with flood and tsunami latched and tsunami displayed, clear tsunami via ack → disp_sel=0 on the next edge.
- **Escalation (DISASTER_ESCALATE_EN, ESC_CYCLES=16):** hold ALERT with no ack → escalate=1 on the 16th cycle. ack → ACKED and escalate=0.

Source files
------------

// File: rtl/disaster_pkg.sv
// disaster_pkg: shared hazard indices, alarm FSM states and display-rotation helpers
// Ports: none (package).
package disaster_pkg;
    localparam int NUM_HAZARDS = 4;
    localparam logic [1:0] HZ_FLOOD   = 2'd0;
    localparam logic [1:0] HZ_CYCLONE = 2'd1;
    localparam logic [1:0] HZ_QUAKE   = 2'd2;
    localparam logic [1:0] HZ_TSUNAMI = 2'd3;

    typedef enum logic [1:0] {SAFE, ALERT, ACKED} alarm_state_t;

    // Highest-priority latched hazard: tsunami > quake > cyclone > flood.
    function automatic logic [1:0] top_idx(input logic [3:0] m);
        top_idx = m[3] ? HZ_TSUNAMI : m[2] ? HZ_QUAKE : m[1] ? HZ_CYCLONE : HZ_FLOOD;
    endfunction

    // Next latched index strictly above cur with wrap; falls back to cur when it is the only one.
    function automatic logic [1:0] next_idx(input logic [3:0] m, input logic [1:0] cur);
        next_idx = cur;
        for (int k = 3; k >= 1; k--)
            if (m[cur + 2'(k)]) next_idx = cur + 2'(k);
    endfunction
endpackage

// File: rtl/hazard_persist.sv
// hazard_persist: per-hazard persistence counter and alarm latch
// Ports: clk, rst (sync, active-high); flag, sample_valid from the detector;
//        clr_req = operator ack; latched = registered latch; latched_nxt = its next-state value.
module hazard_persist #(
    parameter int PERSIST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    input  logic sample_valid,
    input  logic clr_req,
    output logic latched,
    output logic latched_nxt
);
    localparam int CW = $clog2(PERSIST + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic latched_q, latched_d;
    always_comb begin
        cnt_d = cnt_q;
        if (sample_valid) cnt_d = !flag ? '0 : (cnt_q == CW'(PERSIST)) ? cnt_q : cnt_q + CW'(1);
        // Set wins over clear; clear only once the condition has gone (counter back at 0).
        latched_d = (cnt_d == CW'(PERSIST)) ? 1'b1 : (clr_req && cnt_q == '0) ? 1'b0 : latched_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            latched_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            latched_q <= latched_d;
        end
    end
    assign latched     = latched_q;
    assign latched_nxt = latched_d;
endmodule

// File: rtl/disaster_alarm_controller.sv
// disaster_alarm_controller: hazard persistence, alarm latching, SAFE/ALERT/ACKED FSM and display rotation
// Ports: clk, rst (sync, active-high); sample_valid, hazard_in[3:0] {tsunami,quake,cyclone,flood}; ack;
//        alarm_latched[3:0], disp_sel[1:0], disp_valid, buzzer, safe_led, danger_led;
//        escalate (only when DISASTER_ESCALATE_EN is defined, along with parameter ESC_CYCLES).
module disaster_alarm_controller
    import disaster_pkg::*;
#(
    parameter int PERSIST     = 4,
    parameter int HOLD_CYCLES = 8
`ifdef DISASTER_ESCALATE_EN
    ,
    parameter int ESC_CYCLES  = 64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [3:0] hazard_in,
    input  logic       ack,
    output logic [3:0] alarm_latched,
    output logic [1:0] disp_sel,
    output logic       disp_valid,
    output logic       buzzer,
    output logic       safe_led,
    output logic       danger_led
`ifdef DISASTER_ESCALATE_EN
    ,
    output logic       escalate
`endif
);
    localparam int DW = $clog2(HOLD_CYCLES + 1);
    logic [3:0] lat_q, lat_d;
    alarm_state_t state_q, state_d;
    logic [1:0] disp_sel_q, disp_sel_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic disp_valid_q, buzzer_q, safe_q, danger_q;
    logic any_d, new_set;

    for (genvar i = 0; i < NUM_HAZARDS; i++) begin : g_hz
        hazard_persist #(.PERSIST(PERSIST)) u_persist (
            .clk         (clk),
            .rst         (rst),
            .flag        (hazard_in[i]),
            .sample_valid(sample_valid),
            .clr_req     (ack),
            .latched     (lat_q[i]),
            .latched_nxt (lat_d[i])
        );
    end

    assign any_d   = lat_d != '0;
    assign new_set = |(lat_d & ~lat_q);

    // FSM decides on next-state latches so the LEDs/buzzer move on the same edge as the latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SAFE:    state_d = any_d ? ALERT : SAFE;
            ALERT:   state_d = !any_d ? SAFE : (ack && !new_set) ? ACKED : ALERT;
            ACKED:   state_d = !any_d ? SAFE : new_set ? ALERT : ACKED;
            default: state_d = SAFE;
        endcase
    end

    // Display follows next-state latches so disp_sel never points at a cleared hazard while disp_valid.
    always_comb begin
        disp_sel_d = disp_sel_q;
        dwell_d    = '0;
        if (lat_q == '0 && any_d) disp_sel_d = top_idx(lat_d);
        else if (any_d && !lat_d[disp_sel_q]) disp_sel_d = next_idx(lat_d, disp_sel_q);
        else if (any_d && dwell_q == DW'(HOLD_CYCLES - 1)) disp_sel_d = next_idx(lat_d, disp_sel_q);
        else if (any_d) dwell_d = dwell_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SAFE;
            disp_sel_q   <= '0;
            dwell_q      <= '0;
            disp_valid_q <= 1'b0;
            buzzer_q     <= 1'b0;
            safe_q       <= 1'b1;
            danger_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_sel_q   <= disp_sel_d;
            dwell_q      <= dwell_d;
            disp_valid_q <= any_d;
            buzzer_q     <= state_d == ALERT;
            safe_q       <= state_d == SAFE;
            danger_q     <= state_d != SAFE;
        end
    end

`ifdef DISASTER_ESCALATE_EN
    localparam int EW = $clog2(ESC_CYCLES + 1);
    logic [EW-1:0] esc_q, esc_d;
    logic escalate_q, escalate_d;
    always_comb begin
        esc_d      = (state_q == ALERT && state_d == ALERT) ?
                     ((esc_q == EW'(ESC_CYCLES)) ? esc_q : esc_q + EW'(1)) : '0;
        escalate_d = state_d == ALERT && esc_d == EW'(ESC_CYCLES);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            esc_q      <= '0;
            escalate_q <= 1'b0;
        end else begin
            esc_q      <= esc_d;
            escalate_q <= escalate_d;
        end
    end
    assign escalate = escalate_q;
`endif

    assign alarm_latched = lat_q;
    assign disp_sel      = disp_sel_q;
    assign disp_valid    = disp_valid_q;
    assign buzzer        = buzzer_q;
    assign safe_led      = safe_q;
    assign danger_led    = danger_q;
endmodule

// File: tb/tb_disaster_alarm_controller.sv
// tb_disaster_alarm_controller: table vectors, hand sequences and random run against a reference model
module tb_disaster_alarm_controller;
    localparam int PERSIST = 4;
    localparam int HOLD    = 8;
    localparam int ESC     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] hazard_in = 4'h0;
    logic       ack = 1'b0;
    logic [3:0] alarm_latched;
    logic [1:0] disp_sel;
    logic       disp_valid, buzzer, safe_led, danger_led;
`ifdef DISASTER_ESCALATE_EN
    logic       escalate;
`endif

    int vectors = 0;
    int miscompares = 0;

    disaster_alarm_controller #(
        .PERSIST(PERSIST),
        .HOLD_CYCLES(HOLD)
`ifdef DISASTER_ESCALATE_EN
        , .ESC_CYCLES(ESC)
`endif
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .hazard_in(hazard_in), .ack(ack),
        .alarm_latched(alarm_latched), .disp_sel(disp_sel), .disp_valid(disp_valid),
        .buzzer(buzzer), .safe_led(safe_led), .danger_led(danger_led)
`ifdef DISASTER_ESCALATE_EN
        , .escalate(escalate)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: plain integers, state as 0=SAFE 1=ALERT 2=ACKED.
    int       m_cnt[4];
    bit [3:0] m_lat;
    int       m_st, m_sel, m_dwell, m_esc;
    bit       m_dv, m_escal;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_lat = 0; m_st = 0; m_sel = 0; m_dwell = 0; m_esc = 0; m_dv = 0; m_escal = 0;
    endtask

    function automatic int next_up(input bit [3:0] m, input int cur);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    task automatic model(input bit r, input bit sv, input bit [3:0] hz, input bit a);
        int nc[4];
        bit [3:0] nl;
        bit newb;
        int ns;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            nc[i] = !sv ? m_cnt[i] : !hz[i] ? 0 : (m_cnt[i] < PERSIST ? m_cnt[i] + 1 : PERSIST);
            nl[i] = (nc[i] == PERSIST) || (m_lat[i] && !(a && m_cnt[i] == 0));
        end
        newb = |(nl & ~m_lat);
        if (nl == 0) ns = 0;
        else if (m_st == 0) ns = 1;
        else if (m_st == 1) ns = (a && !newb) ? 2 : 1;
        else ns = newb ? 1 : 2;
        if (m_lat == 0 && nl != 0) begin
            m_sel = nl[3] ? 3 : nl[2] ? 2 : nl[1] ? 1 : 0;
            m_dwell = 0;
        end else if (nl == 0) m_dwell = 0;
        else if (!nl[m_sel] || m_dwell == HOLD - 1) begin
            m_sel = next_up(nl, m_sel);
            m_dwell = 0;
        end else m_dwell++;
        m_esc = (m_st == 1 && ns == 1) ? (m_esc < ESC ? m_esc + 1 : ESC) : 0;
        m_escal = (ns == 1) && (m_esc == ESC);
        m_st = ns;
        for (int i = 0; i < 4; i++) m_cnt[i] = nc[i];
        m_lat = nl;
        m_dv = nl != 0;
    endtask

    task automatic check(input string nm, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {alarm_latched, disp_sel, disp_valid, buzzer, safe_led, danger_led};
    endfunction

    task automatic tick(input bit r, input bit sv, input bit [3:0] hz, input bit a);
        logic [9:0] exp;
        rst = r; sample_valid = sv; hazard_in = hz; ack = a;
        model(r, sv, hz, a);
        @(posedge clk);
        #1;
        exp = {m_lat, 2'(m_sel), m_dv, m_st == 1, m_st == 0, m_st != 0};
        check("model", outs(), exp);
`ifdef DISASTER_ESCALATE_EN
        check("model_escalate", {9'b0, escalate}, {9'b0, m_escal});
`endif
    endtask

    typedef struct {
        logic       r;
        logic       sv;
        logic [3:0] hz;
        logic       a;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // exp = {latched[3:0], disp_sel[1:0], disp_valid, buzzer, safe_led, danger_led}
        tbl[0]  = '{1'b1, 1'b1, 4'hf, 1'b0, 10'b0000_00_0010};
        tbl[1]  = '{1'b1, 1'b1, 4'hf, 1'b0, 10'b0000_00_0010};
        tbl[2]  = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0000_00_0010};
        tbl[3]  = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0000_00_0010};
        tbl[4]  = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0000_00_0010};
        tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 10'b0000_00_0010};
        tbl[6]  = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0000_00_0010};
        tbl[7]  = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0000_00_0010};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 10'b0000_00_0010};
        tbl[9]  = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0000_00_0010};
        tbl[10] = '{1'b0, 1'b1, 4'h1, 1'b0, 10'b0001_00_1101};
        tbl[11] = '{1'b0, 1'b1, 4'h1, 1'b1, 10'b0001_00_1001};
        tbl[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 10'b0001_00_1001};
        tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 10'b0000_00_0010};
        model_reset();
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].r, tbl[i].sv, tbl[i].hz, tbl[i].a);
            check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
        end
`ifdef DISASTER_ESCALATE_EN
        check("reset_escalate", {9'b0, escalate}, 10'd0);
`endif

        // Quake and tsunami latch together; display 3 -> 2 -> 3 every HOLD cycles.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'hc, 1'b0);
        check("qt_latch", {6'b0, alarm_latched}, 10'h00c);
        check("qt_sel_first", {8'b0, disp_sel}, 10'd3);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("qt_sel_before", {8'b0, disp_sel}, 10'd3);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("qt_sel_rot", {8'b0, disp_sel}, 10'd2);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("qt_sel_wrap", {8'b0, disp_sel}, 10'd3);

        // Ack into ACKED, then a new cyclone latch on an ack edge returns to ALERT.
        tick(1'b0, 1'b1, 4'he, 1'b1);
        check("acked_buzzer", {9'b0, buzzer}, 10'd0);
        check("acked_danger", {9'b0, danger_led}, 10'd1);
        tick(1'b0, 1'b1, 4'he, 1'b0);
        tick(1'b0, 1'b1, 4'he, 1'b0);
        tick(1'b0, 1'b1, 4'he, 1'b1);
        check("cyc_ack_latch", {6'b0, alarm_latched}, 10'h00e);
        check("cyc_ack_buzzer", {9'b0, buzzer}, 10'd1);

        // Flood + tsunami latched with tsunami shown; clearing tsunami moves display to flood.
        tick(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h9, 1'b0);
        check("ft_sel", {6'b0, alarm_latched, disp_sel}, {6'b0, 4'h9, 2'd3} >> 0);
        tick(1'b0, 1'b1, 4'h1, 1'b0);
        check("ft_hold", {4'b0, alarm_latched, disp_sel}, {4'b0, 4'h9, 2'd3});
        tick(1'b0, 1'b0, 4'h0, 1'b1);
        check("ft_clear", {4'b0, alarm_latched, disp_sel}, {4'b0, 4'h1, 2'd0});

`ifdef DISASTER_ESCALATE_EN
        tick(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h1, 1'b0);
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("esc_early", {9'b0, escalate}, 10'd0);
        tick(1'b0, 1'b0, 4'h0, 1'b0);
        check("esc_on", {9'b0, escalate}, 10'd1);
        tick(1'b0, 1'b0, 4'h0, 1'b1);
        check("esc_ack", {8'b0, escalate, buzzer}, 10'd0);
`endif

        // Randomized run against the reference model; two bias levels for hazard density.
        tick(1'b1, 1'b0, 4'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            bit [3:0] hz;
            int pct;
            pct = (n < 1500) ? 85 : 55;
            for (int b = 0; b < 4; b++) hz[b] = $urandom_range(0, 99) < pct;
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, hz, $urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
